// File: rtl/ex_stage_if.sv
// ID/EX-side operands and control into the execute stage, EX/MEM pipeline register out.
// slave is the execute stage's view; master is the driver/observer side.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] alu_input1_in;
    logic [XLEN-1:0] alu_input2_in;
    logic [XLEN-1:0] data_memory_store_in;
    logic [2:0]      alu_control_in;
    logic            reg_write_in;
    logic [4:0]      rd_address_in;
    logic            data_mem_write_in;
    logic [1:0]      alu_or_load_or_pc_plus_four_in;
    logic [XLEN-1:0] pc_plus_four_in;

    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] data_memory_store_out;
    logic            reg_write_out;
    logic [4:0]      rd_address_out;
    logic            data_mem_write_out;
    logic [1:0]      alu_or_load_or_pc_plus_four_out;
    logic [XLEN-1:0] pc_plus_four_out;

    modport slave (
        input  alu_input1_in, alu_input2_in, data_memory_store_in, alu_control_in,
               reg_write_in, rd_address_in, data_mem_write_in,
               alu_or_load_or_pc_plus_four_in, pc_plus_four_in,
        output alu_result_out, data_memory_store_out, reg_write_out, rd_address_out,
               data_mem_write_out, alu_or_load_or_pc_plus_four_out, pc_plus_four_out
    );

    modport master (
        output alu_input1_in, alu_input2_in, data_memory_store_in, alu_control_in,
               reg_write_in, rd_address_in, data_mem_write_in,
               alu_or_load_or_pc_plus_four_in, pc_plus_four_in,
        input  alu_result_out, data_memory_store_out, reg_write_out, rd_address_out,
               data_mem_write_out, alu_or_load_or_pc_plus_four_out, pc_plus_four_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier (1 bit/cycle)
// that stalls upstream and feeds bubbles into EX/MEM until the product is ready.
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    output logic        stall_out,
    ex_stage_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(XLEN - 1);

    logic [0:0]         state;
    logic [SHAMT_W-1:0] count;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    mcand;
    logic [XLEN-1:0]    mplier;

    // Fields of the multiply instruction, held while ID_EX is frozen
    logic [XLEN-1:0]    l_store;
    logic               l_reg_write;
    logic [4:0]         l_rd;
    logic               l_mem_write;
    logic [1:0]         l_wb_sel;
    logic [XLEN-1:0]    l_pc4;

    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    next_acc;
    logic               last;
    logic               is_mul;

    assign is_mul   = (bus.alu_control_in == OP_MUL);
    assign last     = (count == LAST);
    assign next_acc = acc + (mplier[0] ? mcand : '0);

    assign stall_out = !flush && (((state == IDLE) && is_mul) || ((state == BUSY) && !last));

    always_comb begin
        alu_result = '0;
        unique case (bus.alu_control_in)
            OP_ADD: alu_result = bus.alu_input1_in + bus.alu_input2_in;
            OP_SUB: alu_result = bus.alu_input1_in - bus.alu_input2_in;
            OP_AND: alu_result = bus.alu_input1_in & bus.alu_input2_in;
            OP_OR:  alu_result = bus.alu_input1_in | bus.alu_input2_in;
            OP_XOR: alu_result = bus.alu_input1_in ^ bus.alu_input2_in;
            OP_SLT: alu_result = {{(XLEN-1){1'b0}},
                                  ($signed(bus.alu_input1_in) < $signed(bus.alu_input2_in))};
            OP_SLL: alu_result = bus.alu_input1_in << bus.alu_input2_in[SHAMT_W-1:0];
            OP_MUL: alu_result = '0;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                               <= IDLE;
            count                               <= '0;
            acc                                 <= '0;
            mcand                               <= '0;
            mplier                              <= '0;
            l_store                             <= '0;
            l_reg_write                         <= 1'b0;
            l_rd                                <= '0;
            l_mem_write                         <= 1'b0;
            l_wb_sel                            <= '0;
            l_pc4                               <= '0;
            bus.alu_result_out                  <= '0;
            bus.data_memory_store_out           <= '0;
            bus.reg_write_out                   <= 1'b0;
            bus.rd_address_out                  <= '0;
            bus.data_mem_write_out              <= 1'b0;
            bus.alu_or_load_or_pc_plus_four_out <= '0;
            bus.pc_plus_four_out                <= '0;
        end else begin
            // Bubble by default; the branches below override when a real result retires
            bus.alu_result_out                  <= '0;
            bus.data_memory_store_out           <= '0;
            bus.reg_write_out                   <= 1'b0;
            bus.rd_address_out                  <= '0;
            bus.data_mem_write_out              <= 1'b0;
            bus.alu_or_load_or_pc_plus_four_out <= '0;
            bus.pc_plus_four_out                <= '0;

            if (flush) begin
                state <= IDLE;
                count <= '0;
            end else if (state == IDLE) begin
                if (is_mul) begin
                    mcand       <= bus.alu_input1_in;
                    mplier      <= bus.alu_input2_in;
                    acc         <= '0;
                    count       <= '0;
                    l_store     <= bus.data_memory_store_in;
                    l_reg_write <= bus.reg_write_in;
                    l_rd        <= bus.rd_address_in;
                    l_mem_write <= bus.data_mem_write_in;
                    l_wb_sel    <= bus.alu_or_load_or_pc_plus_four_in;
                    l_pc4       <= bus.pc_plus_four_in;
                    state       <= BUSY;
                end else begin
                    bus.alu_result_out                  <= alu_result;
                    bus.data_memory_store_out           <= bus.data_memory_store_in;
                    bus.reg_write_out                   <= bus.reg_write_in;
                    bus.rd_address_out                  <= bus.rd_address_in;
                    bus.data_mem_write_out              <= bus.data_mem_write_in;
                    bus.alu_or_load_or_pc_plus_four_out <= bus.alu_or_load_or_pc_plus_four_in;
                    bus.pc_plus_four_out                <= bus.pc_plus_four_in;
                end
            end else begin
                acc    <= next_acc;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + SHAMT_W'(1);
                if (last) begin
                    bus.alu_result_out                  <= next_acc;
                    bus.data_memory_store_out           <= l_store;
                    bus.reg_write_out                   <= l_reg_write;
                    bus.rd_address_out                  <= l_rd;
                    bus.data_mem_write_out              <= l_mem_write;
                    bus.alu_or_load_or_pc_plus_four_out <= l_wb_sel;
                    bus.pc_plus_four_out                <= l_pc4;
                    count                               <= '0;
                    state                               <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, MUL timing/stall, flush and reset aborts.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic stall_out;
    int   n_chk  = 0;
    int   n_fail = 0;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall_out (stall_out),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic [4:0] rd, input logic mw,
                         input logic [1:0] sel, input logic [31:0] pc4, input logic [31:0] st);
        bus.alu_control_in                 = op;
        bus.alu_input1_in                  = a;
        bus.alu_input2_in                  = b;
        bus.reg_write_in                   = rw;
        bus.rd_address_in                  = rd;
        bus.data_mem_write_in              = mw;
        bus.alu_or_load_or_pc_plus_four_in = sel;
        bus.pc_plus_four_in                = pc4;
        bus.data_memory_store_in           = st;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] alu, input logic [31:0] st,
                           input logic rw, input logic [4:0] rd, input logic mw,
                           input logic [1:0] sel, input logic [31:0] pc4);
        chk({tag, "/alu"},   bus.alu_result_out, alu);
        chk({tag, "/store"}, bus.data_memory_store_out, st);
        chk({tag, "/rw"},    32'(bus.reg_write_out), 32'(rw));
        chk({tag, "/rd"},    32'(bus.rd_address_out), 32'(rd));
        chk({tag, "/mw"},    32'(bus.data_mem_write_out), 32'(mw));
        chk({tag, "/sel"},   32'(bus.alu_or_load_or_pc_plus_four_out), 32'(sel));
        chk({tag, "/pc4"},   bus.pc_plus_four_out, pc4);
    endtask

    // Runs edges 1..32 after a MUL was presented in IDLE; caller drives the next instruction
    // and clocks edge 33 itself.
    task automatic mul_wait(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk({tag, "/bubble_rw"}, 32'(bus.reg_write_out), 32'd0);
            chk({tag, "/bubble_rd"}, 32'(bus.rd_address_out), 32'd0);
            chk({tag, "/stall"}, 32'(stall_out), (i <= 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        tick();
        chk_out("reset", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0);
        chk("reset/stall", 32'(stall_out), 32'd0);
        reset = 1'b0;

        // Single-cycle ops, 1-cycle latency with full pass-through
        drive(3'b000, 32'd5, 32'hFFFF_FFFD, 1'b1, 5'd7, 1'b0, 2'd2, 32'h104, 32'hAA);
        #1 chk("add/stall", 32'(stall_out), 32'd0);
        tick();
        chk_out("add", 32'd2, 32'hAA, 1'b1, 5'd7, 1'b0, 2'd2, 32'h104);

        drive(3'b001, 32'd3, 32'd5, 1'b1, 5'd8, 1'b1, 2'd1, 32'h108, 32'h55);
        tick();
        chk_out("sub", 32'hFFFF_FFFE, 32'h55, 1'b1, 5'd8, 1'b1, 2'd1, 32'h108);

        drive(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 5'd9, 1'b0, 2'd0, 32'h10C, 32'h0);
        tick();
        chk("and", bus.alu_result_out, 32'hF000_F000);
        drive(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 5'd9, 1'b0, 2'd0, 32'h110, 32'h0);
        tick();
        chk("or", bus.alu_result_out, 32'hFFF0_FFF0);
        drive(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 5'd9, 1'b0, 2'd0, 32'h114, 32'h0);
        tick();
        chk("xor", bus.alu_result_out, 32'h0FF0_0FF0);
        drive(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd10, 1'b0, 2'd0, 32'h118, 32'h0);
        tick();
        chk("slt_neg", bus.alu_result_out, 32'd1);
        drive(3'b101, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd10, 1'b0, 2'd0, 32'h11C, 32'h0);
        tick();
        chk("slt_pos", bus.alu_result_out, 32'd0);
        drive(3'b110, 32'd1, 32'h23, 1'b1, 5'd11, 1'b0, 2'd0, 32'h120, 32'h0);
        tick();
        chk("sll", bus.alu_result_out, 32'd8);
        drive(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd12, 1'b0, 2'd0, 32'h124, 32'h0);
        tick();
        chk("add_wrap", bus.alu_result_out, 32'd0);

        // ID_EX bubble passes through as ADD 0+0 with no writeback
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk_out("idex_bubble", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0);

        // MUL 7*6: product appears on edge 33
        drive(3'b111, 32'd7, 32'd6, 1'b1, 5'd5, 1'b0, 2'd0, 32'h200, 32'h77);
        #1 chk("mul76/stall0", 32'(stall_out), 32'd1);
        mul_wait("mul76");
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk_out("mul76", 32'd42, 32'h77, 1'b1, 5'd5, 1'b0, 2'd0, 32'h200);
        chk("mul76/stall_after", 32'(stall_out), 32'd0);

        drive(3'b111, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd6, 1'b0, 2'd0, 32'h0, 32'h0);
        mul_wait("mulneg");
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("mulneg/alu", bus.alu_result_out, 32'hFFFF_FFFE);

        drive(3'b111, 32'h0001_0000, 32'h0001_0000, 1'b1, 5'd6, 1'b0, 2'd0, 32'h0, 32'h0);
        mul_wait("mulovf");
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("mulovf/alu", bus.alu_result_out, 32'h0);
        chk("mulovf/rw", 32'(bus.reg_write_out), 32'd1);

        // Back-to-back MULs, results 33 edges apart
        drive(3'b111, 32'd3, 32'd4, 1'b1, 5'd3, 1'b0, 2'd0, 32'h0, 32'h0);
        mul_wait("b2b_1");
        drive(3'b111, 32'd5, 32'd5, 1'b1, 5'd4, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("b2b_1/alu", bus.alu_result_out, 32'd12);
        chk("b2b_1/rd", 32'(bus.rd_address_out), 32'd3);
        chk("b2b_2/stall0", 32'(stall_out), 32'd1);
        mul_wait("b2b_2");
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("b2b_2/alu", bus.alu_result_out, 32'd25);
        chk("b2b_2/rd", 32'(bus.rd_address_out), 32'd4);

        // Flush mid-multiply: stall drops at once, bubble follows, FSM back in IDLE
        drive(3'b111, 32'd9, 32'd9, 1'b1, 5'd9, 1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("flush/stall_before", 32'(stall_out), 32'd1);
        flush = 1'b1;
        #1 chk("flush/stall", 32'(stall_out), 32'd0);
        tick();
        flush = 1'b0;
        drive(3'b000, 32'd1, 32'd1, 1'b1, 5'd2, 1'b0, 2'd0, 32'h0, 32'h0);
        chk_out("flush_bubble", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0);
        #1 chk("flush/idle_stall", 32'(stall_out), 32'd0);
        tick();
        chk("flush/next_alu", bus.alu_result_out, 32'd2);
        chk("flush/next_rd", 32'(bus.rd_address_out), 32'd2);

        // Reset mid-multiply: abort, no product ever written
        drive(3'b111, 32'd7, 32'd6, 1'b1, 5'd5, 1'b1, 2'd3, 32'h300, 32'h33);
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mid_reset", 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0);
        drive(3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        #1 chk("mid_reset/stall", 32'(stall_out), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("mid_reset/no_rw", 32'(bus.reg_write_out), 32'd0);
            chk("mid_reset/no_result", bus.alu_result_out, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
